// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM state
// encoding, the opcodes the controller recognises, and the datapath mux
// select values it drives.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

endpackage

// File: rtl/ctrl_instret_cnt.sv
// Retired-instruction counter.
//   clk : core clock
//   clr : synchronous clear (priority over inc)
//   inc : count one retired instruction
//   cnt : current count, wraps modulo 2^W
module ctrl_instret_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback one state per cycle and drives the datapath
// selects, write strobes and the memory request/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   opcode, funct3, zero: instruction fields from IR and ALU zero flag
//   mem_ready           : memory completes the current request this cycle
//   mem_req, adrSrc, memWrite, irWrite, pcUpdate, regWrite : strobes/selects
//   resultSrc, aluSrcA, aluSrcB, aluOp : datapath mux selects
//   illegal             : sticky illegal-instruction flag
//   instret             : retired-instruction count
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adrSrc,
  output logic             memWrite,
  output logic             irWrite,
  output logic             pcUpdate,
  output logic             regWrite,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_nx;
  logic   retire;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:    if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXECR;
          OP_I:              state_nx = S_EXECI;
          OP_BRANCH:         state_nx = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_nx = S_JAL;
          OP_LUI:            state_nx = S_LUI;
          default:           state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_nx = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_JAL:      state_nx = S_ALUWB;
      S_LUI:      state_nx = S_ALUWB;
      S_ILLEGAL:  state_nx = S_ILLEGAL;
      default:    state_nx = S_FETCH;
    endcase
  end

  // Retirement is the return to FETCH from a final state; reset suppresses it.
  assign retire = !rst && (state_nx == S_FETCH) &&
                  (state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == S_ILLEGAL)
        illegal <= 1'b1;
    end
  end

  // Outputs decode from state; strobes are masked by rst so no write fires
  // in a reset cycle regardless of the state being left.
  always_comb begin
    logic s_mem_req, s_mem_write, s_ir_write, s_pc_update, s_reg_write;
    s_mem_req   = 1'b0;
    s_mem_write = 1'b0;
    s_ir_write  = 1'b0;
    s_pc_update = 1'b0;
    s_reg_write = 1'b0;
    adrSrc      = 1'b0;
    resultSrc   = RES_ALUOUT;
    aluSrcA     = SRCA_PC;
    aluSrcB     = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    unique case (state)
      S_FETCH: begin
        s_mem_req   = 1'b1;
        aluSrcB     = SRCB_FOUR;
        resultSrc   = RES_ALU;
        s_ir_write  = mem_ready;
        s_pc_update = mem_ready;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        s_mem_req = 1'b1;
        adrSrc    = 1'b1;
      end
      S_MEMWB: begin
        resultSrc   = RES_MEM;
        s_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        s_mem_req   = 1'b1;
        adrSrc      = 1'b1;
        s_mem_write = 1'b1;
      end
      S_EXECR: begin
        aluSrcA = SRCA_RS1;
        aluOp   = ALUOP_FUNC;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNC;
      end
      S_ALUWB: s_reg_write = 1'b1;
      S_BRANCH: begin
        aluSrcA     = SRCA_RS1;
        aluOp       = ALUOP_SUB;
        s_pc_update = zero ^ funct3[0];
      end
      S_JAL: begin
        aluSrcA     = SRCA_OLDPC;
        aluSrcB     = SRCB_FOUR;
        s_pc_update = 1'b1;
      end
      S_LUI: begin
        aluSrcA = SRCA_ZERO;
        aluSrcB = SRCB_IMM;
      end
      default: ;
    endcase
    mem_req  = s_mem_req   & ~rst;
    memWrite = s_mem_write & ~rst;
    irWrite  = s_ir_write  & ~rst;
    pcUpdate = s_pc_update & ~rst;
    regWrite = s_reg_write & ~rst;
  end

  ctrl_instret_cnt #(.W(CNT_W)) u_instret (
    .clk (clk),
    .clr (rst),
    .inc (retire),
    .cnt (instret)
  );

endmodule
